// File: rtl/ifu_ibus_ctrl.sv
// ifu_ibus_ctrl: instruction-bus request controller between fetch and the instruction bus.
//
// Issues single-outstanding word reads on a req/gnt/rvalid bus for fetch's next_pc and
// returns the word for fetch's current pc. A one-entry hold buffer keeps the last returned
// word presented while fetch stalls. Responses whose address no longer matches pc are
// stored but never shown as valid.
//
// Ports:
//   cpu_clk, cpu_rstn        clock, asynchronous active-low reset
//   next_pc, pc              fetch next and current pc
//   instr_read_data_valid    instruction for pc is present
//   instr_read_data          instruction word, 0 when not valid
//   ibus_req, ibus_addr      bus read request and address (held until ibus_gnt)
//   ibus_gnt                 request accepted this cycle
//   ibus_rvalid, ibus_rdata  read response
//   ibus_err                 bus error, qualified by ibus_rvalid (KRV_IBUS_ERR_EN only)
//   instr_access_fault       valid word carries a bus error (KRV_IBUS_ERR_EN only)
//
// Build option: define KRV_IBUS_ERR_EN to add bus-error tracking and the fault output.

module ifu_ibus_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rstn,
  input  logic [ADDR_WIDTH-1:0]  next_pc,
  input  logic [ADDR_WIDTH-1:0]  pc,
  output logic                   instr_read_data_valid,
  output logic [INSTR_WIDTH-1:0] instr_read_data,
`ifdef KRV_IBUS_ERR_EN
  input  logic                   ibus_err,
  output logic                   instr_access_fault,
`endif
  output logic                   ibus_req,
  output logic [ADDR_WIDTH-1:0]  ibus_addr,
  input  logic                   ibus_gnt,
  input  logic                   ibus_rvalid,
  input  logic [INSTR_WIDTH-1:0] ibus_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                 state_q, state_d;
  logic                   ibus_req_q, ibus_req_d;
  logic [ADDR_WIDTH-1:0]  ibus_addr_q, ibus_addr_d;
  logic [ADDR_WIDTH-1:0]  req_tag_q, req_tag_d;
  logic                   hold_vld_q, hold_vld_d;
  logic [ADDR_WIDTH-1:0]  hold_tag_q, hold_tag_d;
  logic [INSTR_WIDTH-1:0] hold_data_q, hold_data_d;
`ifdef KRV_IBUS_ERR_EN
  logic                   hold_err_q, hold_err_d;
`endif

  logic issue;
  logic byp;
  logic hit;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q     <= StIdle;
      ibus_req_q  <= 1'b0;
      ibus_addr_q <= '0;
      req_tag_q   <= '0;
      hold_vld_q  <= 1'b0;
      hold_tag_q  <= '0;
      hold_data_q <= '0;
`ifdef KRV_IBUS_ERR_EN
      hold_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ibus_req_q  <= ibus_req_d;
      ibus_addr_q <= ibus_addr_d;
      req_tag_q   <= req_tag_d;
      hold_vld_q  <= hold_vld_d;
      hold_tag_q  <= hold_tag_d;
      hold_data_q <= hold_data_d;
`ifdef KRV_IBUS_ERR_EN
      hold_err_q  <= hold_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    ibus_req_d  = ibus_req_q;
    ibus_addr_d = ibus_addr_q;
    req_tag_d   = req_tag_q;
    hold_vld_d  = hold_vld_q;
    hold_tag_d  = hold_tag_q;
    hold_data_d = hold_data_q;
`ifdef KRV_IBUS_ERR_EN
    hold_err_d  = hold_err_q;
`endif
    issue       = 1'b0;

    case (state_q)
      StIdle: begin
        // Nothing to fetch if the held word already covers next cycle's pc.
        if (!(hold_vld_q && (hold_tag_q == next_pc))) begin
          issue = 1'b1;
        end
      end
      StReq: begin
        // Request and address stay put until accepted, even across a redirect.
        if (ibus_gnt) begin
          ibus_req_d = 1'b0;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (ibus_rvalid) begin
          hold_data_d = ibus_rdata;
          hold_tag_d  = req_tag_q;
          hold_vld_d  = 1'b1;
`ifdef KRV_IBUS_ERR_EN
          hold_err_d  = ibus_err;
`endif
          if (next_pc != req_tag_q) begin
            issue = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A new request invalidates the hold buffer, overriding any capture above.
    if (issue) begin
      ibus_addr_d = next_pc;
      req_tag_d   = next_pc;
      ibus_req_d  = 1'b1;
      hold_vld_d  = 1'b0;
`ifdef KRV_IBUS_ERR_EN
      hold_err_d  = 1'b0;
`endif
      state_d     = StReq;
    end
  end

  always_comb begin
    byp = (state_q == StWait) && ibus_rvalid && (req_tag_q == pc);
    hit = hold_vld_q && (hold_tag_q == pc);
    instr_read_data_valid = byp || hit;
    if (byp) begin
      instr_read_data = ibus_rdata;
    end else if (hit) begin
      instr_read_data = hold_data_q;
    end else begin
      instr_read_data = '0;
    end
`ifdef KRV_IBUS_ERR_EN
    instr_access_fault = (byp && ibus_err) || (hit && hold_err_q);
    if (instr_access_fault) begin
      instr_read_data = '0;
    end
`endif
  end

  assign ibus_req  = ibus_req_q;
  assign ibus_addr = ibus_addr_q;

endmodule

// File: tb/tb_ifu_ibus_ctrl.sv
module tb_ifu_ibus_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 32;

  logic          cpu_clk = 1'b0;
  logic          cpu_rstn = 1'b0;
  logic [AW-1:0] next_pc = '0;
  logic [AW-1:0] pc = '0;
  logic          instr_read_data_valid;
  logic [IW-1:0] instr_read_data;
  logic          ibus_req;
  logic [AW-1:0] ibus_addr;
  logic          ibus_gnt = 1'b0;
  logic          ibus_rvalid = 1'b0;
  logic [IW-1:0] ibus_rdata = '0;
  logic          ibus_err = 1'b0;
`ifdef KRV_IBUS_ERR_EN
  logic          instr_access_fault;
`endif

  ifu_ibus_ctrl #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
    .cpu_clk               (cpu_clk),
    .cpu_rstn              (cpu_rstn),
    .next_pc               (next_pc),
    .pc                    (pc),
    .instr_read_data_valid (instr_read_data_valid),
    .instr_read_data       (instr_read_data),
`ifdef KRV_IBUS_ERR_EN
    .ibus_err              (ibus_err),
    .instr_access_fault    (instr_access_fault),
`endif
    .ibus_req              (ibus_req),
    .ibus_addr             (ibus_addr),
    .ibus_gnt              (ibus_gnt),
    .ibus_rvalid           (ibus_rvalid),
    .ibus_rdata            (ibus_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are checked 1ns later.
  task automatic apply(input logic [31:0] np, input logic [31:0] pcv, input logic g,
                       input logic rv, input logic [31:0] rd, input logic er);
    @(negedge cpu_clk);
    next_pc     = np;
    pc          = pcv;
    ibus_gnt    = g;
    ibus_rvalid = rv;
    ibus_rdata  = rd;
    ibus_err    = er;
    #1;
  endtask

  // Reset, then release with next_pc=np presented; the next rising edge is cycle 0 -> 1.
  task automatic do_reset(input logic [31:0] np);
    @(negedge cpu_clk);
    cpu_rstn = 1'b0;
    next_pc = '0; pc = '0; ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = '0; ibus_err = 1'b0;
    #1;
    chk("rst_req", ibus_req, 0);
    chk("rst_addr", ibus_addr, 0);
    chk("rst_valid", instr_read_data_valid, 0);
    chk("rst_data", instr_read_data, 0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    next_pc = np;
    pc = np;
    #1;
    chk("rel_req", ibus_req, 0);
    chk("rel_valid", instr_read_data_valid, 0);
  endtask

  typedef struct {
    logic [31:0] np;
    logic [31:0] pcv;
    logic        g;
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[10];

  // Reference model: a pending-request flag, a queue of granted addresses awaiting data,
  // and a one-word buffer.
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_infl[$];
  logic        m_bv;
  logic [31:0] m_btag;
  logic [31:0] m_bdata;
  logic        m_berr;

  task automatic m_reset();
    m_req = 1'b0; m_addr = '0; m_infl.delete();
    m_bv = 1'b0; m_btag = '0; m_bdata = '0; m_berr = 1'b0;
  endtask

  task automatic m_update(input logic [31:0] np, input logic g, input logic rv,
                          input logic [31:0] rd, input logic er);
    logic        granted;
    logic        issue;
    logic [31:0] tag;
    granted = m_req && g;
    issue = 1'b0;
    if (rv && m_infl.size() != 0) begin
      tag = m_infl.pop_front();
      m_bv = 1'b1; m_btag = tag; m_bdata = rd; m_berr = er;
      issue = (np != tag);
    end else if (!m_req && m_infl.size() == 0 && !(m_bv && m_btag == np)) begin
      issue = 1'b1;
    end
    if (granted) begin
      m_infl.push_back(m_addr);
      m_req = 1'b0;
    end
    if (issue) begin
      m_req = 1'b1; m_addr = np; m_bv = 1'b0; m_berr = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] np, pcv, rd, prev_np, e_data;
    logic        g, rv, er, byp, hit, e_vld, e_flt;

    // Latency and stall sequence, starting with next_pc=0 at reset release.
    vecs[0] = '{32'h0,  32'h0,  1'b1, 1'b0, 32'h0,        1'b1, 32'h0,  1'b0, 32'h0};
    vecs[1] = '{32'h10, 32'h0,  1'b0, 1'b1, 32'h13,       1'b0, 32'h0,  1'b1, 32'h13};
    vecs[2] = '{32'h10, 32'h10, 1'b1, 1'b0, 32'h0,        1'b1, 32'h10, 1'b0, 32'h0};
    vecs[3] = '{32'h10, 32'h10, 1'b0, 1'b1, 32'hABCD0001, 1'b0, 32'h10, 1'b1, 32'hABCD0001};
    for (int i = 4; i < 8; i++)
      vecs[i] = '{32'h10, 32'h10, 1'b0, 1'b0, 32'h0,      1'b0, 32'h10, 1'b1, 32'hABCD0001};
    vecs[8] = '{32'h14, 32'h10, 1'b0, 1'b0, 32'h0,        1'b0, 32'h10, 1'b1, 32'hABCD0001};
    vecs[9] = '{32'h14, 32'h14, 1'b0, 1'b0, 32'h0,        1'b1, 32'h14, 1'b0, 32'h0};

    do_reset(32'h0);
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].np, vecs[i].pcv, vecs[i].g, vecs[i].rv, vecs[i].rd, 1'b0);
      chk($sformatf("vec%0d_req", i), ibus_req, vecs[i].e_req);
      chk($sformatf("vec%0d_addr", i), ibus_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_valid", i), instr_read_data_valid, vecs[i].e_vld);
      chk($sformatf("vec%0d_data", i), instr_read_data, vecs[i].e_data);
    end

    // Redirect while waiting: the 0x8 word is never valid, 0x100 requested on rvalid edge.
    do_reset(32'h8);
    apply(32'h8, 32'h8, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("redir_req8", ibus_req, 1);
    chk("redir_addr8", ibus_addr, 32'h8);
    apply(32'h100, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("redir_wait_valid", instr_read_data_valid, 0);
    apply(32'h100, 32'h100, 1'b0, 1'b1, 32'hDEAD, 1'b0);
    chk("redir_stale_valid", instr_read_data_valid, 0);
    chk("redir_stale_data", instr_read_data, 0);
    apply(32'h100, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("redir_req100", ibus_req, 1);
    chk("redir_addr100", ibus_addr, 32'h100);
    chk("redir_after_valid", instr_read_data_valid, 0);

    // Grant withheld three cycles: request and address stay stable.
    do_reset(32'h4);
    for (int i = 0; i < 3; i++) begin
      apply(32'h4, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0);
      chk($sformatf("hold%0d_req", i), ibus_req, 1);
      chk($sformatf("hold%0d_addr", i), ibus_addr, 32'h4);
    end
    apply(32'h4, 32'h4, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("hold_gnt_req", ibus_req, 1);
    apply(32'h4, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("hold_drop_req", ibus_req, 0);

`ifdef KRV_IBUS_ERR_EN
    // Bus error on 0x20: fault with zeroed data, both bypassed and from the buffer.
    do_reset(32'h20);
    apply(32'h20, 32'h20, 1'b1, 1'b0, 32'h0, 1'b0);
    apply(32'h20, 32'h20, 1'b0, 1'b1, 32'hFFFF, 1'b1);
    chk("err_byp_fault", instr_access_fault, 1);
    chk("err_byp_valid", instr_read_data_valid, 1);
    chk("err_byp_data", instr_read_data, 0);
    apply(32'h20, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("err_hit_fault", instr_access_fault, 1);
    chk("err_hit_valid", instr_read_data_valid, 1);
    chk("err_hit_data", instr_read_data, 0);
`endif

    // Reset while waiting, then a stray rvalid after release.
    do_reset(32'h40);
    apply(32'h40, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0);
    apply(32'h40, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
    cpu_rstn = 1'b0;
    #1;
    chk("midrst_req", ibus_req, 0);
    chk("midrst_valid", instr_read_data_valid, 0);
    cpu_rstn = 1'b1;
    next_pc = 32'h44;
    ibus_rvalid = 1'b1;
    ibus_rdata = 32'h55;
    #1;
    chk("stray_valid", instr_read_data_valid, 0);
    chk("stray_data", instr_read_data, 0);
    chk("stray_req", ibus_req, 0);
    apply(32'h44, 32'h44, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("fresh_req", ibus_req, 1);
    chk("fresh_addr", ibus_addr, 32'h44);
    chk("fresh_valid", instr_read_data_valid, 0);

    // Randomized run against the reference model.
    do_reset(32'h0);
    m_reset();
    m_update(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    prev_np = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      pcv = prev_np;
      case ($urandom_range(0, 3))
        0, 1:    np = pcv;
        2:       np = pcv + 32'd4;
        default: np = 32'($urandom_range(0, 7)) << 2;
      endcase
      g  = m_req ? 1'($urandom_range(0, 1)) : 1'b0;
      rv = (m_infl.size() != 0) ? ($urandom_range(0, 2) != 0) : 1'b0;
      rd = $urandom;
`ifdef KRV_IBUS_ERR_EN
      er = ($urandom_range(0, 3) == 0);
`else
      er = 1'b0;
`endif
      apply(np, pcv, g, rv, rd, er);

      byp = rv && (m_infl.size() != 0) && (m_infl[0] == pcv);
      hit = m_bv && (m_btag == pcv);
      e_vld = byp || hit;
      e_data = byp ? rd : (hit ? m_bdata : 32'h0);
      e_flt = (byp && er) || (hit && m_berr);
      if (e_flt) e_data = 32'h0;
      chk("rnd_req", ibus_req, m_req);
      chk("rnd_addr", ibus_addr, m_addr);
      chk("rnd_valid", instr_read_data_valid, e_vld);
      chk("rnd_data", instr_read_data, e_data);
`ifdef KRV_IBUS_ERR_EN
      chk("rnd_fault", instr_access_fault, e_flt);
`endif
      m_update(np, g, rv, rd, er);
      prev_np = np;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
